piso_frame_serializer: RTL and testbench
========================================

# piso_frame_serializer

Parametrised parallel-in/serial-out frame serializer with valid/ready load handshake, run-time MSB-first or LSB-first bit order, bit counter, busy/done status and zero-bubble back-to-back frames. It sits between a parallel word producer and a single-wire serial transmit path. It replaces the fixed-order, free-running shift register with a controller that knows where each frame starts and ends.

## Interface
- DW, 9, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enb  input  1  clock enable. When low, all state, counter and outputs freeze. No handshake is accepted.
- lsb_first  input  1  bit order for the next accepted word: 1 = LSB first, 0 = MSB first. Sampled only at acceptance.
- in_valid  input  1  producer offers inp.
- inp  input  DW  parallel data word.
- in_ready  output  1  serializer can accept a word this cycle.
- out  output  1  serial data. Idle level is 1.
- out_valid  output  1  out carries a frame bit this cycle.
- busy  output  1  a frame is in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse after a frame's last bit.

## Operation
- Internal state: shift register sr[DW-1:0], order flag ord, bit counter cnt of width $clog2(DW+1), state ∈ {IDLE, SHIFT, PAR}. PAR exists only with the macro.
- Acceptance: a word is accepted at a rising edge when enb & in_valid & in_ready.
- in_ready = enb & (state==IDLE | last_cycle). This is combinational.
- last_cycle is true in either of these cases:
  - state==SHIFT and cnt==DW-1, without parity.
  - state==PAR, with parity.
- IDLE behaviour:
  - out=1, out_valid=0, busy=0.
  - On acceptance: sr←inp, ord←lsb_first, cnt←0, state→SHIFT.
- SHIFT behaviour:
  - out = ord ? sr[0] : sr[DW-1]. out_valid=1, busy=1.
  - On each enb edge, MSB-first: sr←{sr[DW-2:0],1'b1}.
  - On each enb edge, LSB-first: sr←{1'b1,sr[DW-1:1]}.
  - On each enb edge, cnt←cnt+1.
  - At cnt==DW-1 with enb: go to PAR (macro) or to IDLE, with done set next cycle.
- Back-to-back: acceptance during last_cycle reloads sr/ord/cnt=0 and stays in SHIFT. done still pulses. out_valid stays high with no gap bit.
- enb low mid-frame: the current bit holds on out. cnt does not advance. done is not generated.
- in_valid while not ready: ignored. The producer must hold inp until the handshake.
- inp and lsb_first changing after acceptance: no effect on the frame in flight.
- cnt never exceeds DW-1 and is 0 in IDLE.

## Timing
- Reset (asynchronous, any state, including mid-frame): state=IDLE, sr='1, cnt=0, ord=0, done=0, out=1, out_valid=0, busy=0. in_ready follows enb.
- Latency: a word accepted at edge k drives its first bit on out from just after edge k. The frame occupies DW consecutive enb cycles (DW+1 with parity).
- done: registered. It is high for exactly one clk, in the cycle after the edge that consumed the last bit, even if enb is low in that cycle.
- Throughput with enb held high: one word per DW cycles (DW+1 with parity). No idle bit between frames.

## Configuration
- PISO_PARITY_EN defined:
  - An extra bit follows the data in state PAR: even parity = ^word, computed at acceptance and stored.
  - out_valid=1 during PAR. last_cycle = PAR.
- PISO_PARITY_EN undefined:
  - No PAR state, no parity register.
  - The frame is exactly DW bits. last_cycle = (SHIFT & cnt==DW-1).

## Test plan
- Reset/idle: assert reset mid-frame of 9'h1A5 → out=1, out_valid=0, busy=0, done=0 immediately. After release with enb=1, in_ready=1.
- MSB-first: DW=9, inp=9'h1A5, lsb_first=0, enb=1 → out = 1,1,0,1,0,0,1,0,1 on 9 cycles, then done pulse one cycle, then out=1 idle.
- LSB-first: inp=9'h1A5, lsb_first=1 → out = 1,0,1,0,0,1,0,1,1. Flipping lsb_first mid-frame has no effect.
- Back-to-back: in_valid held with 9'h1FF then 9'h000 → 18 contiguous valid bits (nine 1s, nine 0s). done pulses after each frame. in_ready is high only on accept cycles.
- enb gating: drop enb for 3 cycles at bit 4 of 9'h0F0 → out holds bit 4, cnt frozen, no acceptance. The frame completes 3 cycles later with the correct sequence.
- Parity (macro defined): inp=9'h1A5 (five 1s) → 9 data bits followed by parity bit 1. done follows the 10th bit.

Source files
------------

// File: rtl/piso_frame_serializer.sv
// -----------------------------------------------------------------------------
// piso_frame_serializer
//
// Parallel-in / serial-out frame serializer. A DW-bit word is taken over a
// valid/ready handshake and shifted out one bit per enabled clock, MSB-first or
// LSB-first as chosen by lsb_first at the moment of acceptance. A new word can
// be taken during the last bit of the current frame, so frames follow each
// other with no idle bit in between.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   : each frame carries one extra even-parity bit (^word) after the
//               data bits, sent in state PAR.
//   undefined : frames are exactly DW bits; no PAR state, no parity register.
//
// Parameters
//   DW         data word width, 2..32
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   enb        clock enable; when low the frame freezes and nothing is accepted
//   lsb_first  bit order for the next accepted word (1 = LSB first)
//   in_valid   producer offers inp
//   inp        parallel data word
//   in_ready   serializer can take a word this cycle (combinational)
//   out        serial data, idle level 1
//   out_valid  out carries a frame bit this cycle
//   busy       a frame is in progress
//   done       one-cycle pulse in the cycle after a frame's last bit
// -----------------------------------------------------------------------------
module piso_frame_serializer #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  input  logic          lsb_first,
  input  logic          in_valid,
  input  logic [DW-1:0] inp,
  output logic          in_ready,
  output logic          out,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  localparam int              CW       = $clog2(DW + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DW - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t        state_reg, state_next;
  logic [DW-1:0] sr_reg,    sr_next;
  logic          ord_reg,   ord_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic          done_reg,  done_next;
`ifdef PISO_PARITY_EN
  logic          par_reg,   par_next;
`endif

  logic last_cycle;
  logic accept;

  // The cycle in which the final bit of the frame is on the wire; a new word
  // may be loaded here so the next frame starts right after it.
`ifdef PISO_PARITY_EN
  assign last_cycle = (state_reg == PAR);
`else
  assign last_cycle = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);
`endif

  assign in_ready = enb & ((state_reg == IDLE) | last_cycle);
  assign accept   = enb & in_valid & in_ready;
  assign done     = done_reg;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sr_reg    <= '1;
      ord_reg   <= 1'b0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      ord_reg   <= ord_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
`ifdef PISO_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    ord_next   = ord_reg;
    cnt_next   = cnt_reg;
    // done is updated every clk (not gated by enb) so the pulse lasts exactly
    // one clock even if enb drops right after the last bit.
    done_next  = enb & last_cycle;
`ifdef PISO_PARITY_EN
    par_next   = par_reg;
`endif
    if (enb) begin
      case (state_reg)
        SHIFT: begin
          // Vacated positions fill with 1 so a drained register reads idle.
          sr_next = ord_reg ? {1'b1, sr_reg[DW-1:1]} : {sr_reg[DW-2:0], 1'b1};
          if (cnt_reg == CNT_LAST) begin
`ifdef PISO_PARITY_EN
            // cnt stays at DW-1 while the parity bit is out.
            state_next = PAR;
`else
            state_next = IDLE;
            cnt_next   = '0;
`endif
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
`endif
        default: ;
      endcase
      // Acceptance overrides the end-of-frame transition: back-to-back load.
      if (accept) begin
        sr_next    = inp;
        ord_next   = lsb_first;
        cnt_next   = '0;
        state_next = SHIFT;
`ifdef PISO_PARITY_EN
        par_next   = ^inp;
`endif
      end
    end
  end

  // Outputs
  always_comb begin
    out       = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      SHIFT: begin
        out       = ord_reg ? sr_reg[0] : sr_reg[DW-1];
        out_valid = 1'b1;
        busy      = 1'b1;
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        out       = par_reg;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
module tb_piso_frame_serializer;

  localparam int DW = 9;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = DW + (PAR_EN ? 1 : 0);

  logic          clk = 1'b0;
  logic          reset;
  logic          enb;
  logic          lsb_first;
  logic          in_valid;
  logic [DW-1:0] inp;
  logic          in_ready;
  logic          out;
  logic          out_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  piso_frame_serializer #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .lsb_first (lsb_first),
    .in_valid  (in_valid),
    .inp       (inp),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bits still to appear on the wire for the current
  // frame, plus the pending done pulse.
  bit mq[$];
  bit m_done;

  task automatic model_reset();
    mq.delete();
    m_done = 1'b0;
  endtask

  task automatic model_step(input logic e, v, l, input logic [DW-1:0] d);
    int n;
    bit rdy;
    n = mq.size();
    rdy = e && (n <= 1);
    m_done = e && (n == 1);
    if (e && n > 0) void'(mq.pop_front());
    if (e && v && rdy) begin
      for (int i = 0; i < DW; i++) mq.push_back(l ? d[i] : d[DW-1-i]);
      if (PAR_EN) mq.push_back(^d);
    end
  endtask

  logic s_out, s_ov, s_rdy, s_done;

  // One clock cycle: drive, sample, compare with the model, advance.
  task automatic cyc(input logic e, v, l, input logic [DW-1:0] d);
    enb = e; in_valid = v; lsb_first = l; inp = d;
    #1;
    s_out = out; s_ov = out_valid; s_rdy = in_ready; s_done = done;
    check("out",       out,       (mq.size() != 0) ? mq[0] : 1'b1);
    check("out_valid", out_valid, mq.size() != 0);
    check("busy",      busy,      mq.size() != 0);
    check("in_ready",  in_ready,  e && (mq.size() <= 1));
    check("done",      done,      m_done);
    model_step(e, v, l, d);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic e, v, l;
    logic [DW-1:0] d;
    logic o, ov, rdy, b, dn;
  } vec_t;
  vec_t tbl[$];

  task automatic add_frame(input logic l, input logic [DW-1:0] w,
                           input logic [0:DW-1] seq, input logic par);
    tbl.push_back('{1'b1, 1'b1, l, w, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    // Flip lsb_first and inp mid-frame: must not disturb the frame.
    for (int i = 0; i < DW; i++)
      tbl.push_back('{1'b1, 1'b0, ~l, ~w, seq[i], 1'b1,
                      (i == DW-1) && !PAR_EN, 1'b1, 1'b0});
    if (PAR_EN) tbl.push_back('{1'b1, 1'b0, ~l, ~w, par, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    logic [0:DW-1] msb_seq;
    logic [0:DW-1] lsb_seq;
    logic [DW-1:0] word;
    int acc, nvalid, ndone, idx, hold, guard, p;
    logic e;

    reset = 1'b0; enb = 1'b0; lsb_first = 1'b0; in_valid = 1'b0; inp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",       out,       1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_ready_enb0", in_ready, 0);
    enb = 1'b1; #1;
    check("rst_ready_enb1", in_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven MSB/LSB frames ----------------
    msb_seq = 9'b110100101;
    lsb_seq = 9'b101001011;
    add_frame(1'b0, 9'h1A5, msb_seq, 1'b1);
    add_frame(1'b1, 9'h1A5, lsb_seq, 1'b1);
    for (int r = 0; r < tbl.size(); r++) begin
      enb = tbl[r].e; in_valid = tbl[r].v; lsb_first = tbl[r].l; inp = tbl[r].d;
      #1;
      check($sformatf("tbl%0d_out", r),       out,       tbl[r].o);
      check($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
      check($sformatf("tbl%0d_in_ready", r),  in_ready,  tbl[r].rdy);
      check($sformatf("tbl%0d_busy", r),      busy,      tbl[r].b);
      check($sformatf("tbl%0d_done", r),      done,      tbl[r].dn);
      $display("tbl row %0d: out=%0b out_valid=%0b in_ready=%0b busy=%0b done=%0b",
               r, out, out_valid, in_ready, busy, done);
      model_step(tbl[r].e, tbl[r].v, tbl[r].l, tbl[r].d);
      @(posedge clk); #1;
    end

    // ---------------- asynchronous reset mid-frame ----------------
    cyc(1'b1, 1'b1, 1'b0, 9'h1A5);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, '0);
    reset = 1'b0;
    #1;
    check("midrst_out",       out,       1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy",      busy,      0);
    check("midrst_done",      done,      0);
    model_reset();
    enb = 1'b0; in_valid = 1'b0; #1;
    check("midrst_ready_enb0", in_ready, 0);
    enb = 1'b1; #1;
    check("midrst_ready_enb1", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    $display("reset mid-frame: out=%0b busy=%0b in_ready=%0b", out, busy, in_ready);

    // ---------------- back-to-back frames ----------------
    acc = 0; nvalid = 0; ndone = 0; p = 0;
    for (int c = 0; c < 2*FL + 3; c++) begin
      cyc(1'b1, acc < 2, 1'b0, (acc == 0) ? 9'h1FF : 9'h000);
      if (acc < 2 && s_rdy) acc++;
      if (s_ov) begin
        nvalid++;
        check("b2b_bit", s_out, p < FL);
        p++;
      end
      if (s_done) ndone++;
    end
    check("b2b_accepts", acc, 2);
    check("b2b_valid_bits", nvalid, 2*FL);
    check("b2b_done_pulses", ndone, 2);
    $display("back-to-back: valid_bits=%0d done_pulses=%0d", nvalid, ndone);

    // ---------------- enb gating mid-frame ----------------
    cyc(1'b1, 1'b1, 1'b0, 9'h0F0);
    idx = 0; hold = 0; guard = 0; ndone = 0; word = '0;
    while (idx < FL && guard < 40) begin
      e = !(idx == 4 && hold < 3);
      if (!e) hold++;
      cyc(e, !e, 1'b0, e ? 9'h000 : 9'h1FF);
      if (!e) begin
        check("gate_hold_out", s_out, 1);
        check("gate_no_ready", s_rdy, 0);
      end
      if (e && s_ov) begin
        if (idx < DW) word = {word[DW-2:0], s_out};
        idx++;
      end
      if (s_done) ndone++;
      guard++;
    end
    check("gate_frame_len", idx, FL);
    repeat (2) begin
      cyc(1'b1, 1'b0, 1'b0, '0);
      if (s_done) ndone++;
    end
    check("gate_word", word, 9'h0F0);
    check("gate_done", ndone, 1);
    $display("enb gating: word=%03h done_pulses=%0d", word, ndone);

    // ---------------- randomized against the model ----------------
    for (int c = 0; c < 800; c++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
          1'($urandom), DW'($urandom));
    end
    $display("random: 800 cycles compared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
